cnt_seq_ctrl: RTL
=================

// Module: cnt_seq_ctrl
// PURPOSE
//  Sequencer for the binary counter datapath: starts, pauses, aborts and terminates a count run against a
//  programmable terminal value. Runs one-shot or periodic. Emits a one-cycle done strobe per completed run.
//  Drives en_out for an external counter's enable. Sits between control logic and the counter/timer datapath.
// PARAMETERS
//  W      3   counter / limit width in bits
// PORTS
//  clk     in   1   clock, all state updates on rising edge
//  rst     in   1   asynchronous reset, active-high
//  start   in   1   begin run: load limit/mode, clear count
//  abort   in   1   cancel run, return to IDLE
//  hold    in   1   freeze count while in RUN
//  mode    in   1   0 = one-shot, 1 = periodic (sampled with start)
//  limit   in   W   terminal count (sampled with start)
//  cnt     out  W   current count
//  en_out  out  1   combinational: state==RUN && !hold && !abort
//  busy    out  1   high in RUN or HOLD
//  done    out  1   registered one-cycle strobe after terminal count
// BEHAVIOUR
//  - One clock (clk); reset rst is asynchronous, active-high.
//  - Reset values: state=IDLE, cnt=0, limit_q=0, mode_q=0, busy=0, done=0; en_out=0.
//  - States: IDLE, RUN, HOLD, DONE.
//  - Priority each edge: abort > start > hold > count.
//  - IDLE: start -> RUN, cnt<=0, limit_q<=limit, mode_q<=mode. Otherwise stay; cnt unchanged.
//  - RUN, no hold, cnt!=limit_q: cnt<=cnt+1.
//  - RUN, no hold, cnt==limit_q, mode_q=0: -> DONE, cnt holds at limit_q, done<=1.
//  - RUN, no hold, cnt==limit_q, mode_q=1: stay RUN, cnt<=0, done<=1.
//  - RUN with hold -> HOLD, cnt frozen. HOLD with hold -> stay. HOLD without hold -> RUN (no count that edge).
//  - DONE lasts one cycle -> IDLE. start in DONE -> RUN, same as from IDLE.
//  - start in RUN or HOLD restarts the run: cnt<=0, limit/mode re-latched, state RUN, no done.
//  - abort in any state: -> IDLE, cnt<=0, done<=0; beats a same-edge start and a same-edge terminal count.
//  - done is high exactly one cycle per terminal count. It is cleared on every other edge.
//  - Latency: start at edge k, limit L. First cnt=0 after k; cnt=L after k+L; done high after edge k+L+1.
//  - Period in mode 1 with no hold = L+1 cycles.
//  - limit=0: one-shot gives done in the 2nd cycle after start. Periodic gives done every cycle from then on.
//  - Arithmetic is W-bit unsigned. cnt never exceeds limit_q, so there is no wrap beyond the terminal value.
//  - Mid-run reset returns to reset values asynchronously; a pending done is lost.
// CONFIGURATION
//  CNT_SEQ_PERIOD_CNT_EN defined: adds port periods out 8. It is a saturating count of done strobes since
//    the last start (periodic mode only); reset 0, cleared by start and abort, saturates at 255.
//  Undefined: port and logic absent; all other behaviour identical.
// TESTING
//  1. Reset mid-RUN (cnt=2): assert rst asynchronously -> cnt=0, busy=0, done=0 immediately, no clock needed.
//  2. One-shot, limit=5: start for 1 cycle -> cnt 0..5, done high 7th cycle after start edge, then IDLE, busy=0.
//  3. Periodic, limit=2: start -> cnt 0,1,2,0,1,2; done every 3rd cycle; en_out stays 1.
//  4. Periodic, limit=7, hold 3 cycles at cnt=4 -> cnt stays 4, en_out=0, busy=1; resumes 5,6,7; done 4 cycles late.
//  5. Abort + start same edge at cnt=6, limit=6 -> IDLE, cnt=0, no done. limit=0 one-shot -> done 2nd cycle.
//  6. With CNT_SEQ_PERIOD_CNT_EN, limit=0, periodic for 300 cycles -> periods=255; start -> periods=0.

Source files
------------

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: run sequencer for a binary counter (start/hold/abort, one-shot or periodic, done strobe).
// Optional feature macro: CNT_SEQ_PERIOD_CNT_EN adds a saturating 8-bit count of periodic done strobes.
module cnt_seq_ctrl #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         hold,
    input  logic         mode,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         en_out,
    output logic         busy,
`ifdef CNT_SEQ_PERIOD_CNT_EN
    output logic [7:0]   periods,
`endif
    output logic         done
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d, limit_q, limit_d;
    logic         mode_q, mode_d, done_q, done_d;
`ifdef CNT_SEQ_PERIOD_CNT_EN
    logic [7:0]   periods_q, periods_d;
`endif
    // next state: abort beats start, start beats hold, hold beats counting
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (start) begin
            state_d = RUN;
            cnt_d   = '0;
            limit_d = limit;
            mode_d  = mode;
        end else begin
            case (state_q)
                RUN: begin
                    if (hold) state_d = HOLD;
                    else if (cnt_q != limit_q) cnt_d = cnt_q + 1'b1;
                    else begin
                        done_d  = 1'b1;
                        cnt_d   = mode_q ? '0 : cnt_q;
                        state_d = mode_q ? RUN : DONE;
                    end
                end
                HOLD:    state_d = hold ? HOLD : RUN;
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end
`ifdef CNT_SEQ_PERIOD_CNT_EN
    // periods counts terminal counts of a periodic run, cleared by start or abort
    always_comb begin
        periods_d = periods_q;
        if (abort || start) periods_d = '0;
        else if (done_d && mode_q && periods_q != 8'hFF) periods_d = periods_q + 8'd1;
    end
    // periods register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) periods_q <= '0;
        else     periods_q <= periods_d;
    end
    assign periods = periods_q;
`endif
    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end
    assign cnt    = cnt_q;
    assign done   = done_q;
    assign busy   = (state_q == RUN) || (state_q == HOLD);
    assign en_out = (state_q == RUN) && !hold && !abort;
endmodule
